riscv_muldiv: RTL
=================

Name: riscv_muldiv

Overview:
Iterative multiply/divide unit implementing the RISC-V M extension (plus RV64 *W forms) for the multicycle core. It sits beside ula64 in the datapath. The control FSM issues a start pulse with rs1/rs2 from the A/B registers and funct3 from the instruction, then stalls until done. The result feeds the write-back mux into the register bank.

Parameters:
XLEN, 64, datapath width; legal values 32 or 64.
SUPPORT_W, 1, enables *W ops (32-bit operate, sign-extend to XLEN); must be 0 when XLEN=32.

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  reset, asynchronous, active-low.
start  in  1  request; sampled only in IDLE.
funct3  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
op_w  in  1  word form (MULW/DIVW/DIVUW/REMW/REMUW); ignored if SUPPORT_W=0.
rs1  in  XLEN  operand 1 (dividend / multiplicand).
rs2  in  XLEN  operand 2 (divisor / multiplier).
flush  in  1  synchronous abort (exception/EPC path).
busy  out  1  high whenever state != IDLE.
done  out  1  one-cycle pulse; result valid.
result  out  XLEN  result; holds until the next accepted start.

Behaviour:
- Reset (RST=0, async): state IDLE, busy=0, done=0, result=0, all internal registers cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE with start=1: latch funct3, op_w and conditioned operands. N = 32 if op_w, else XLEN. Counter loads N.
  - Special case (div/rem with divisor==0, or signed overflow MIN/-1): go directly to DONE.
  - Otherwise go to CALC.
- start in any other state: ignored, with no queueing.
- CALC: exactly N cycles.
  - Multiply: radix-2 shift-add on magnitudes, 2N-bit product.
  - Divide: restoring, one quotient bit per cycle on magnitudes.
  - Counter decrements each cycle. When it reaches 1, go to FIX.
- FIX (1 cycle): apply sign correction and select the result. Then go to DONE.
  - MUL/MULW: low N bits.
  - MULH/MULHSU/MULHU: high N bits. MULH treats both operands as signed; MULHSU treats rs1 signed, rs2 unsigned.
  - Signed division: quotient is negative iff operand signs differ and the quotient is nonzero. Remainder takes the sign of the dividend.
  - *W: 32-bit result sign-extended to XLEN (DIVUW/REMUW included, per ISA).
- DONE (1 cycle): done=1, result already registered. Next state is IDLE.
- Latency:
  - Normal op: start sampled at edge k, done high during cycle k+N+2.
  - Special case: done high during cycle k+1.
  - Back-to-back: next start is accepted the cycle after DONE.
- Divide-by-zero:
  - DIV/DIVU quotient = all ones (N bits, sign-extended for W).
  - REM/REMU = dividend (low N bits, sign-extended for W).
- Signed overflow (dividend = -2^(N-1), divisor = -1): DIV quotient = dividend; REM = 0.
- *W operands: only low 32 bits of rs1/rs2 are used; upper bits are don't-care.
- flush=1 in any non-IDLE state: next state IDLE, done=0, result unchanged. flush has priority over the FSM advance. flush in IDLE has no effect, even with start=1, and start is not accepted that cycle.
- RST deasserted mid-operation: the operation is lost; the unit restarts in IDLE.
- Invariant: done implies busy; busy=0 implies done=0.

Decomposition:
- Package riscv_muldiv_pkg:
  - funct3 enum (MUL..REMU).
  - FSM state enum.
  - Localparams for W width (32) and counter width ($clog2(XLEN)+1).
- One combinational sub-module, muldiv_operand_prep, used once:
  - Takes rs1/rs2/funct3/op_w.
  - Produces magnitudes, sign flags, and div-by-zero/overflow flags.
- Iteration datapath and FSM stay in riscv_muldiv.

Test Plan:
- XLEN=64: MUL rs1=7, rs2=0xFFFF_FFFF_FFFF_FFFD -> result 0xFFFF_FFFF_FFFF_FFEB; done exactly 66 cycles after start edge; busy high throughout.
- MULHU rs1=rs2=0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE; MULH with the same operands -> 0.
- DIV 100/0 -> 0xFFFF_FFFF_FFFF_FFFF, done at cycle k+1. REM 100/0 -> 100. DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000. REM of the same -> 0.
- DIVW rs1=0x0000_0001_FFFF_FFF9, rs2=2 -> 0xFFFF_FFFF_FFFF_FFFD in 34 cycles. REMW of the same -> 0xFFFF_FFFF_FFFF_FFFF. REMU -7/2 (64-bit) -> 1.
- flush asserted 10 cycles into DIVU -> IDLE next cycle, no done pulse, result keeps the prior value. Immediately issue DIVU 20/6 -> 3.
- RST low mid-CALC -> busy=0, done=0, result=0 immediately (async). start held high during CALC is ignored and yields a single done pulse.

Source files
------------

// File: rtl/riscv_muldiv_pkg.sv
// Shared types and constants for the iterative RISC-V M-extension unit.
package riscv_muldiv_pkg;

  // Operation selector, encoded exactly like the instruction funct3 field
  typedef enum logic [2:0] {
    F3_MUL    = 3'd0,
    F3_MULH   = 3'd1,
    F3_MULHSU = 3'd2,
    F3_MULHU  = 3'd3,
    F3_DIV    = 3'd4,
    F3_DIVU   = 3'd5,
    F3_REM    = 3'd6,
    F3_REMU   = 3'd7
  } funct3_e;

  // Control FSM states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Operand width used by the word (*W) forms
  localparam int W_WIDTH = 32;

  // Widest datapath supported; the iteration counter must hold this value
  localparam int XLEN_MAX = 64;
  localparam int CNT_W    = $clog2(XLEN_MAX) + 1;

endpackage

// File: rtl/riscv_muldiv_operand_prep.sv
// Combinational operand conditioning: word selection, sign detection,
// magnitudes for the unsigned iteration, and detection of the division
// cases that bypass the iteration entirely.
module muldiv_operand_prep
  import riscv_muldiv_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int SUPPORT_W = 1
) (
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  funct3_e         i_funct3,
  input  logic            i_opW,
  output logic            o_opW,
  output logic [XLEN-1:0] o_magA,
  output logic [XLEN-1:0] o_magB,
  output logic            o_negA,
  output logic            o_negB,
  output logic            o_divZero,
  output logic            o_overflow
);

  logic                w_signedA;
  logic                w_signedB;
  logic                w_isDiv;
  logic                w_signBitA;
  logic                w_signBitB;
  logic [XLEN_MAX-1:0] w_extA;
  logic [XLEN_MAX-1:0] w_extB;
  logic [XLEN_MAX-1:0] w_extMin;
  logic [XLEN-1:0]     w_valA;
  logic [XLEN-1:0]     w_valB;
  logic [XLEN-1:0]     w_minMag;

  // Decode signedness, pick the active operand width and form magnitudes
  always_comb begin
    o_opW     = i_opW & (SUPPORT_W != 0);
    w_signedA = 1'b0;
    w_signedB = 1'b0;
    case (i_funct3)
      F3_MULH:   begin w_signedA = 1'b1; w_signedB = 1'b1; end
      F3_MULHSU: begin w_signedA = 1'b1; w_signedB = 1'b0; end
      F3_DIV:    begin w_signedA = 1'b1; w_signedB = 1'b1; end
      F3_REM:    begin w_signedA = 1'b1; w_signedB = 1'b1; end
      default:   begin w_signedA = 1'b0; w_signedB = 1'b0; end
    endcase
    w_isDiv = (i_funct3 == F3_DIV) || (i_funct3 == F3_DIVU) ||
              (i_funct3 == F3_REM) || (i_funct3 == F3_REMU);

    w_signBitA = o_opW ? i_rs1[31] : i_rs1[XLEN-1];
    w_signBitB = o_opW ? i_rs2[31] : i_rs2[XLEN-1];
    w_extA     = {{32{w_signedA & i_rs1[31]}}, i_rs1[31:0]};
    w_extB     = {{32{w_signedB & i_rs2[31]}}, i_rs2[31:0]};
    w_valA     = o_opW ? w_extA[XLEN-1:0] : i_rs1;
    w_valB     = o_opW ? w_extB[XLEN-1:0] : i_rs2;

    o_negA = w_signedA & w_signBitA;
    o_negB = w_signedB & w_signBitB;
    o_magA = o_negA ? (~w_valA + 1'b1) : w_valA;
    o_magB = o_negB ? (~w_valB + 1'b1) : w_valB;

    w_extMin = 64'h0000_0000_8000_0000;
    w_minMag = o_opW ? w_extMin[XLEN-1:0] : {1'b1, {(XLEN-1){1'b0}}};

    o_divZero  = w_isDiv & (o_magB == '0);
    o_overflow = w_isDiv & o_negA & o_negB &
                 (o_magB == XLEN'(1)) & (o_magA == w_minMag);
  end

endmodule

// File: rtl/riscv_muldiv.sv
// Iterative multiply/divide unit: one bit per cycle shift-add multiply and
// restoring divide on magnitudes, followed by a single sign-fix cycle.
module riscv_muldiv
  import riscv_muldiv_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int SUPPORT_W = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic            op_w,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int IDX_W = $clog2(XLEN);

  state_e            r_state;
  state_e            w_nextState;
  funct3_e           r_func;
  logic              r_opW;
  logic              r_negA;
  logic              r_negB;
  logic [XLEN-1:0]   r_magA;
  logic [XLEN-1:0]   r_magB;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_result;
  logic [2*XLEN-1:0] r_acc;
  logic [CNT_W-1:0]  r_count;

  logic              w_opW;
  logic [XLEN-1:0]   w_magA;
  logic [XLEN-1:0]   w_magB;
  logic              w_negA;
  logic              w_negB;
  logic              w_divZero;
  logic              w_overflow;
  logic              w_special;
  logic              w_accept;
  logic [CNT_W-1:0]  w_loadCount;
  logic [CNT_W-1:0]  w_countDec;
  logic [IDX_W-1:0]  w_bitIdx;
  logic              w_mulBit;
  logic              w_divBit;
  logic [XLEN:0]     w_remShift;
  logic [XLEN:0]     w_remSub;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_mulHi;
  logic [XLEN-1:0]   w_quoS;
  logic [XLEN-1:0]   w_remS;
  logic [XLEN-1:0]   w_raw;
  logic [XLEN-1:0]   w_fixResult;
  logic [XLEN-1:0]   w_specialResult;

  // Word forms keep only the low 32 bits and sign-extend them to XLEN
  function automatic logic [XLEN-1:0] fitN(input logic [XLEN-1:0] v, input logic w);
    logic [XLEN_MAX-1:0] ext;
    ext = {{32{v[31]}}, v[31:0]};
    return w ? ext[XLEN-1:0] : v;
  endfunction

  muldiv_operand_prep #(
    .XLEN      (XLEN),
    .SUPPORT_W (SUPPORT_W)
  ) u_prep (
    .i_rs1      (rs1),
    .i_rs2      (rs2),
    .i_funct3   (funct3_e'(funct3)),
    .i_opW      (op_w),
    .o_opW      (w_opW),
    .o_magA     (w_magA),
    .o_magB     (w_magB),
    .o_negA     (w_negA),
    .o_negB     (w_negB),
    .o_divZero  (w_divZero),
    .o_overflow (w_overflow)
  );

  assign result = r_result;

  // Next-state selection and status outputs; flush overrides any advance
  always_comb begin
    w_nextState = r_state;
    busy        = (r_state != S_IDLE);
    done        = (r_state == S_DONE);
    if (flush && (r_state != S_IDLE)) begin
      w_nextState = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept) w_nextState = w_special ? S_DONE : S_CALC;
        S_CALC:  if (r_count == CNT_W'(1)) w_nextState = S_FIX;
        S_FIX:   w_nextState = S_DONE;
        S_DONE:  w_nextState = S_IDLE;
        default: w_nextState = S_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_nextState;
  end

  // Per-cycle iteration step, sign fix and bypass result for special cases
  always_comb begin
    w_special   = w_divZero | w_overflow;
    w_accept    = (r_state == S_IDLE) & start & ~flush;
    w_loadCount = w_opW ? CNT_W'(W_WIDTH) : CNT_W'(XLEN);

    w_countDec = r_count - CNT_W'(1);
    w_bitIdx   = w_countDec[IDX_W-1:0];
    w_mulBit   = r_magB[w_bitIdx];
    w_divBit   = r_magA[w_bitIdx];
    w_remShift = {r_rem, w_divBit};
    w_remSub   = w_remShift - {1'b0, r_magB};

    w_prod  = (r_negA ^ r_negB) ? (~r_acc + 1'b1) : r_acc;
    w_mulHi = r_opW ? XLEN'(w_prod[63:32]) : w_prod[2*XLEN-1:XLEN];
    w_quoS  = (r_negA ^ r_negB) ? (~r_quo + 1'b1) : r_quo;
    w_remS  = r_negA ? (~r_rem + 1'b1) : r_rem;

    case (r_func)
      F3_MUL:                       w_raw = w_prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: w_raw = w_mulHi;
      F3_DIV, F3_DIVU:              w_raw = w_quoS;
      default:                      w_raw = w_remS;
    endcase
    w_fixResult = fitN(w_raw, r_opW);

    if (w_divZero) w_specialResult = funct3[1] ? fitN(rs1, w_opW) : '1;
    else           w_specialResult = funct3[1] ? '0 : fitN(rs1, w_opW);
  end

  // Operand latch, iteration registers and result register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_func   <= F3_MUL;
      r_opW    <= 1'b0;
      r_negA   <= 1'b0;
      r_negB   <= 1'b0;
      r_magA   <= '0;
      r_magB   <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_func  <= funct3_e'(funct3);
            r_opW   <= w_opW;
            r_negA  <= w_negA;
            r_negB  <= w_negB;
            r_magA  <= w_magA;
            r_magB  <= w_magB;
            r_count <= w_loadCount;
            r_acc   <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            if (w_special) r_result <= w_specialResult;
          end
        end
        S_CALC: begin
          r_count <= w_countDec;
          r_acc   <= (r_acc << 1) + (w_mulBit ? {{XLEN{1'b0}}, r_magA} : '0);
          if (!w_remSub[XLEN]) begin
            r_rem <= w_remSub[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], 1'b1};
          end else begin
            r_rem <= w_remShift[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], 1'b0};
          end
        end
        S_FIX: begin
          if (!flush) r_result <= w_fixResult;
        end
        default: ;
      endcase
    end
  end

endmodule
